// File: rtl/comp_serial.sv
`default_nettype none
// ============================================================================
// Module   : comp_serial
// Purpose  : Multi-cycle two's-complement sign unit. Produces pass, negate,
//            absolute value or negative absolute value of a WIDTH-bit operand,
//            processing CHUNK bits per cycle (LSB chunk first) with a
//            registered carry between chunks. Flags overflow when the
//            most-negative value is inverted.
// Ports    : clk        - clock, all state on rising edge
//            rst        - synchronous active-high reset
//            in_valid   - operand/mode present
//            in_ready   - block can accept (IDLE and not in reset)
//            in_data    - signed operand
//            in_mode    - 00 pass, 01 negate, 10 abs, 11 negative abs
//            out_valid  - result present
//            out_ready  - consumer accepts result
//            out_data   - result (changes only on completion or reset)
//            out_ovf    - result not representable
//            busy       - operation in flight (not IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module comp_serial #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_ovf,
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CW-1:0]    LAST_CNT = CW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   op_q;
    logic [WIDTH-1:0]   acc_q;
    logic               inv_q;
    logic               carry_q;
    logic [CW-1:0]      cnt_q;
    logic               out_valid_q;
    logic [WIDTH-1:0]   out_data_q;
    logic               out_ovf_q;

    logic [CHUNK-1:0]   chunk_w;
    logic [CHUNK:0]     sum_w;
    logic [WIDTH-1:0]   acc_d;
    logic               carry_d;
    logic               inv_d;
    logic               ovf_d;

    // Invert decision taken from the incoming operand at accept time.
    always_comb begin
        inv_d = 1'b0;
        case (in_mode)
            2'b00:   inv_d = 1'b0;
            2'b01:   inv_d = 1'b1;
            2'b10:   inv_d = in_data[WIDTH-1];
            default: inv_d = ~in_data[WIDTH-1];
        endcase
    end

    // Select the operand chunk addressed by the counter.
    always_comb begin
        chunk_w = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                chunk_w = op_q[i*CHUNK +: CHUNK];
            end
        end
    end

    // Conditional one's complement plus carry-in; negation is ~x + 1 with
    // the initial carry seeded by the invert flag.
    assign sum_w   = {1'b0, chunk_w ^ {CHUNK{inv_q}}} + {{CHUNK{1'b0}}, carry_q};
    assign carry_d = sum_w[CHUNK];

    // Partial result with the current chunk merged in.
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < NCHUNK; i++) begin
            if (cnt_q == CW'(i)) begin
                acc_d[i*CHUNK +: CHUNK] = sum_w[CHUNK-1:0];
            end
        end
    end

    // Only the most-negative value has no positive counterpart.
    assign ovf_d = inv_q && (op_q == MIN_VAL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            acc_q       <= '0;
            inv_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q    <= in_data;
                        inv_q   <= inv_d;
                        carry_q <= inv_d;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    acc_q   <= acc_d;
                    carry_q <= carry_d;
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST_CNT) begin
                        out_data_q  <= acc_d;
                        out_ovf_q   <= ovf_d;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE) && !rst;
    assign busy      = (state_q != S_IDLE);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_comp_serial.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_serial
// Purpose  : Self-checking bench for comp_serial, exercising a CHUNK=8 and a
//            CHUNK=32 instance against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_serial;

    localparam int W = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst;
    logic          in_valid  [2];
    logic          in_ready  [2];
    logic [W-1:0]  in_data   [2];
    logic [1:0]    in_mode   [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [W-1:0]  out_data  [2];
    logic          out_ovf   [2];
    logic          busy      [2];

    comp_serial #(.WIDTH(W), .CHUNK(8)) u_dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_mode(in_mode[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_ovf(out_ovf[0]), .busy(busy[0])
    );

    comp_serial #(.WIDTH(W), .CHUNK(32)) u_dut32 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_mode(in_mode[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_ovf(out_ovf[1]), .busy(busy[1])
    );

    int total = 0;
    int bad   = 0;

    // Last completed result each instance should be presenting.
    logic [W-1:0] held_data [2];
    logic         held_ovf  [2];

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic, then wrap; overflow when the exact
    // result falls outside the signed WIDTH-bit range.
    function automatic logic [W:0] model(input logic [1:0] mode, input logic [W-1:0] x);
        longint v, t;
        logic   ovf;
        v = longint'($signed(x));
        case (mode)
            2'd0:    t = v;
            2'd1:    t = -v;
            2'd2:    t = (v < 0) ? -v : v;
            default: t = (v < 0) ? v : -v;
        endcase
        ovf = (t > 64'sd2147483647) || (t < -64'sd2147483648);
        return {ovf, t[W-1:0]};
    endfunction

    function automatic int nchunk(input int s);
        return (s == 0) ? 4 : 1;
    endfunction

    task automatic do_op(input int s, input logic [1:0] mode, input logic [W-1:0] x, input int hold);
        logic [W:0] e;
        int         lat;
        bit         got;
        e = model(mode, x);
        @(negedge clk);
        chk($sformatf("in_ready_idle[%0d]", s), in_ready[s], 1);
        in_valid[s] = 1'b1;
        in_data[s]  = x;
        in_mode[s]  = mode;
        @(posedge clk);
        #1;
        in_valid[s] = 1'b0;
        in_data[s]  = $urandom;
        in_mode[s]  = 2'($urandom_range(0, 3));
        lat = 0;
        got = 0;
        while (!got && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid[s]) begin
                got = 1;
            end else begin
                chk($sformatf("no_partial[%0d]", s), out_data[s], held_data[s]);
                chk($sformatf("in_ready_run[%0d]", s), in_ready[s], 0);
            end
        end
        chk($sformatf("latency[%0d] m=%0d x=%h", s, mode, x), lat, nchunk(s));
        chk($sformatf("data[%0d] m=%0d x=%h", s, mode, x), out_data[s], e[W-1:0]);
        chk($sformatf("ovf[%0d] m=%0d x=%h", s, mode, x), out_ovf[s], e[W]);
        held_data[s] = e[W-1:0];
        held_ovf[s]  = e[W];
        for (int k = 0; k < hold; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("bp_valid[%0d]", s), out_valid[s], 1);
            chk($sformatf("bp_data[%0d]", s), out_data[s], held_data[s]);
            chk($sformatf("bp_ovf[%0d]", s), out_ovf[s], held_ovf[s]);
            chk($sformatf("bp_in_ready[%0d]", s), in_ready[s], 0);
        end
        out_ready[s] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[s] = 1'b0;
        chk($sformatf("valid_drop[%0d]", s), out_valid[s], 0);
        chk($sformatf("idle_busy[%0d]", s), busy[s], 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] x;
        int           s;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_mode[i]   = 2'd0;
            out_ready[i] = 1'b0;
            held_data[i] = '0;
            held_ovf[i]  = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_valid[%0d]", i), out_valid[i], 0);
            chk($sformatf("rst_data[%0d]", i), out_data[i], 0);
            chk($sformatf("rst_ovf[%0d]", i), out_ovf[i], 0);
            chk($sformatf("rst_busy[%0d]", i), busy[i], 0);
            chk($sformatf("rst_in_ready[%0d]", i), in_ready[i], 0);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst[0]", in_ready[0], 1);
        chk("in_ready_after_rst[1]", in_ready[1], 1);

        // Directed cases on the 4-chunk instance.
        do_op(0, 2'd1, 32'h0000_0005, 0);
        chk("neg5_const", held_data[0], 32'hFFFF_FFFB);
        do_op(0, 2'd2, 32'hFFFF_FFFB, 0);
        do_op(0, 2'd2, 32'h0000_0007, 0);
        do_op(0, 2'd3, 32'h0000_0007, 0);
        do_op(0, 2'd0, 32'h1234_5678, 0);
        do_op(0, 2'd1, 32'h0000_0100, 0);
        do_op(0, 2'd1, 32'h0000_0000, 0);
        do_op(0, 2'd1, 32'h8000_0000, 0);
        do_op(0, 2'd2, 32'h8000_0000, 0);
        do_op(0, 2'd3, 32'h8000_0000, 0);
        do_op(0, 2'd1, 32'hCAFE_0001, 3);
        do_op(0, 2'd2, 32'hF00D_0002, 0);

        // Reset while the 4-chunk instance is working on chunk 2.
        @(negedge clk);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'h0000_0009;
        in_mode[0]  = 2'd1;
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_run_busy", busy[0], 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_valid", out_valid[0], 0);
        chk("midrst_data", out_data[0], 0);
        chk("midrst_ovf", out_ovf[0], 0);
        chk("midrst_busy", busy[0], 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_in_ready", in_ready[0], 1);
        for (int i = 0; i < 2; i++) begin
            held_data[i] = '0;
            held_ovf[i]  = 1'b0;
        end
        do_op(0, 2'd1, 32'h0000_0001, 0);
        chk("neg1_const", held_data[0], 32'hFFFF_FFFF);

        // Single-chunk instance.
        do_op(1, 2'd1, 32'h0000_0001, 0);
        do_op(1, 2'd1, 32'h0000_0005, 0);
        do_op(1, 2'd1, 32'h0000_0100, 0);
        do_op(1, 2'd1, 32'h0000_0000, 0);
        do_op(1, 2'd1, 32'h8000_0000, 2);
        do_op(1, 2'd2, 32'h8000_0000, 0);
        do_op(1, 2'd3, 32'h8000_0000, 0);

        // Randomised operations on both instances.
        for (int n = 0; n < 40; n++) begin
            s = int'($urandom_range(0, 1));
            case ($urandom_range(0, 7))
                0:       x = 32'h8000_0000;
                1:       x = 32'h0000_0000;
                2:       x = 32'h7FFF_FFFF;
                3:       x = 32'hFFFF_FFFF;
                default: x = $urandom;
            endcase
            do_op(s, 2'($urandom_range(0, 3)), x, int'($urandom_range(0, 2)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
